// File: rtl/tri_project_sched.sv
// Triangle projection sequencer: fetches triangles, holds the combinational
// projection unit inputs for a settle window, drops clipped results, emits the rest.
module tri_project_sched #(
  parameter int WIIA   = 8,
  parameter int WIFA   = 8,
  parameter int WOI    = 12,
  parameter int SETTLE = 4,
  parameter int AW     = 10,
  localparam int W     = WIIA + WIFA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AW:0]               num_tris,
  input  logic [15:0][W-1:0]        mvp_in,
  output logic                      tri_rd,
  output logic [AW-1:0]             tri_addr,
  input  logic [2:0][3:0][W-1:0]    tri_data,
  output logic [3:0][W-1:0]         pu_vertex_a,
  output logic [3:0][W-1:0]         pu_vertex_b,
  output logic [3:0][W-1:0]         pu_vertex_c,
  output logic [15:0][W-1:0]        pu_mvp,
  input  logic [1:0][WOI-1:0]       pu_V1,
  input  logic [1:0][WOI-1:0]       pu_V2,
  input  logic [1:0][WOI-1:0]       pu_V3,
  input  logic                      pu_clip,
  input  logic [2:0][35:0]          pu_proj_vertex,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0][35:0]          out_tri,
  output logic                      busy,
  output logic                      done,
  output logic [AW:0]               tri_drawn,
  output logic [AW:0]               tri_clipped
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SETTLE, S_EMIT, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [AW:0]               num_q;
  logic [AW-1:0]             idx;
  logic [CW-1:0]             cnt;
  logic [2:0][3:0][W-1:0]    vtx_q;
  logic                      last, settle_end, hs;

  // Screen-space x/y are carried inside pu_proj_vertex; the separate buses are informational.
  logic unused_pu_v;
  assign unused_pu_v = ^{pu_V1, pu_V2, pu_V3};

  assign last       = ({1'b0, idx} == (num_q - 1'b1));
  assign settle_end = (state == S_SETTLE) && (cnt == '0);
  assign hs         = (state == S_EMIT) && out_ready;

  assign tri_addr    = idx;
  assign pu_vertex_a = vtx_q[0];
  assign pu_vertex_b = vtx_q[1];
  assign pu_vertex_c = vtx_q[2];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (num_tris == '0) ? S_DONE : S_FETCH;
      S_FETCH:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == '0) begin
                  if (!pu_clip)  state_nxt = S_EMIT;
                  else if (last) state_nxt = S_DONE;
                  else           state_nxt = S_FETCH;
                end
      S_EMIT:   if (out_ready) state_nxt = last ? S_DONE : S_FETCH;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    tri_rd    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_FETCH: tri_rd    = 1'b1;
      S_EMIT:  out_valid = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  // Datapath: the projection unit inputs only move at start / WAIT_DATA so the
  // combinational unit sees stable operands for the whole settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q       <= '0;
      idx         <= '0;
      cnt         <= '0;
      vtx_q       <= '0;
      pu_mvp      <= '0;
      out_tri     <= '0;
      tri_drawn   <= '0;
      tri_clipped <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        num_q       <= num_tris;
        pu_mvp      <= mvp_in;
        idx         <= '0;
        tri_drawn   <= '0;
        tri_clipped <= '0;
      end
      if (state == S_WAIT) begin
        vtx_q <= tri_data;
        cnt   <= CW'(SETTLE - 1);
      end
      if (state == S_SETTLE && cnt != '0) cnt <= cnt - 1'b1;
      if (settle_end) begin
        out_tri <= pu_proj_vertex;
        if (pu_clip) begin
          tri_clipped <= tri_clipped + 1'b1;
          if (!last) idx <= idx + 1'b1;
        end
      end
      if (hs) begin
        tri_drawn <= tri_drawn + 1'b1;
        if (!last) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tri_project_sched.sv
// Directed bench for tri_project_sched with a behavioural triangle buffer and projection unit.
module tb_tri_project_sched;
  localparam int W = 16, WOI = 12, AW = 10;
  localparam logic [35:0] PK = 36'h5A5A5A5A5;

  logic                   clk = 1'b0;
  logic                   rst_n, start, out_ready;
  logic [AW:0]            num_tris;
  logic [15:0][W-1:0]     mvp_in;
  logic                   tri_rd;
  logic [AW-1:0]          tri_addr;
  logic [2:0][3:0][W-1:0] tri_data;
  logic [3:0][W-1:0]      pu_vertex_a, pu_vertex_b, pu_vertex_c;
  logic [15:0][W-1:0]     pu_mvp;
  logic [1:0][WOI-1:0]    pu_V1, pu_V2, pu_V3;
  logic                   pu_clip;
  logic [2:0][35:0]       pu_proj_vertex;
  logic                   out_valid, busy, done;
  logic [2:0][35:0]       out_tri;
  logic [AW:0]            tri_drawn, tri_clipped;
  logic [W-1:0]           clip_key;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  tri_project_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tris(num_tris), .mvp_in(mvp_in),
    .tri_rd(tri_rd), .tri_addr(tri_addr), .tri_data(tri_data),
    .pu_vertex_a(pu_vertex_a), .pu_vertex_b(pu_vertex_b), .pu_vertex_c(pu_vertex_c),
    .pu_mvp(pu_mvp), .pu_V1(pu_V1), .pu_V2(pu_V2), .pu_V3(pu_V3), .pu_clip(pu_clip),
    .pu_proj_vertex(pu_proj_vertex), .out_valid(out_valid), .out_ready(out_ready),
    .out_tri(out_tri), .busy(busy), .done(done),
    .tri_drawn(tri_drawn), .tri_clipped(tri_clipped)
  );

  // Triangle i: word(v,c) = {v, c, i}, so vertex a's x word equals i.
  function automatic logic [2:0][3:0][W-1:0] gen_tri(input int i);
    logic [2:0][3:0][W-1:0] t;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 4; c++)
        t[v][c] = {4'(v), 4'(c), 8'(i)};
    return t;
  endfunction

  function automatic logic [2:0][35:0] exp_out(input int i);
    logic [2:0][3:0][W-1:0] t;
    logic [63:0]            f;
    logic [2:0][35:0]       e;
    t = gen_tri(i);
    for (int v = 0; v < 3; v++) begin
      f    = t[v];
      e[v] = f[35:0] ^ PK;
    end
    return e;
  endfunction

  // 1-cycle synchronous triangle buffer
  always @(posedge clk) if (tri_rd) tri_data <= gen_tri(int'(tri_addr));

  // Projection unit stand-in
  logic [63:0] fa, fb, fc;
  assign fa = pu_vertex_a;
  assign fb = pu_vertex_b;
  assign fc = pu_vertex_c;
  assign pu_proj_vertex[0] = fa[35:0] ^ PK;
  assign pu_proj_vertex[1] = fb[35:0] ^ PK;
  assign pu_proj_vertex[2] = fc[35:0] ^ PK;
  assign pu_clip = (pu_vertex_a[0] == clip_key);
  assign pu_V1 = '0;
  assign pu_V2 = '0;
  assign pu_V3 = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Three unclipped triangles, rasterizer always ready; called at a negedge while idle.
  task automatic run_nominal3(input string tag);
    logic er;
    start = 1'b1; num_tris = 11'd3; out_ready = 1'b1; clip_key = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 23; cyc++) begin
      er = (cyc == 1 || cyc == 8 || cyc == 15);
      chk({tag, " tri_rd"}, 256'(tri_rd), 256'(er));
      if (er) chk({tag, " tri_addr"}, 256'(tri_addr), 256'((cyc - 1) / 7));
      chk({tag, " out_valid"}, 256'(out_valid), 256'(cyc == 7 || cyc == 14 || cyc == 21));
      if (cyc == 7 || cyc == 14 || cyc == 21)
        chk({tag, " out_tri"}, 256'(out_tri), 256'(exp_out((cyc - 7) / 7)));
      chk({tag, " done"}, 256'(done), 256'(cyc == 22));
      chk({tag, " busy"}, 256'(busy), 256'(cyc <= 22));
      if (cyc == 1) chk({tag, " pu_mvp"}, 256'(pu_mvp), 256'(mvp_in));
      @(negedge clk);
    end
    chk({tag, " drawn"}, 256'(tri_drawn), 256'(3));
    chk({tag, " clipped"}, 256'(tri_clipped), 256'(0));
  endtask

  initial begin
    int hs_cnt;
    logic er;
    for (int i = 0; i < 16; i++) mvp_in[i] = 16'hA000 + 16'(i);
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1; num_tris = 11'd3; clip_key = 16'hFFFF;

    // Reset with start held
    repeat (3) @(negedge clk);
    chk("rst tri_rd", 256'(tri_rd), 256'(0));
    chk("rst out_valid", 256'(out_valid), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst done", 256'(done), 256'(0));
    chk("rst tri_addr", 256'(tri_addr), 256'(0));
    chk("rst pu_mvp", 256'(pu_mvp), 256'(0));
    chk("rst pu_vertex", 256'({pu_vertex_a, pu_vertex_b, pu_vertex_c}), 256'(0));
    chk("rst out_tri", 256'(out_tri), 256'(0));
    chk("rst counts", 256'({tri_drawn, tri_clipped}), 256'(0));
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    run_nominal3("nom");

    // Backpressure: single triangle, ready low for cycles 7..11
    start = 1'b1; num_tris = 11'd1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      out_ready = (cyc < 7 || cyc >= 12);
      chk("bp tri_rd", 256'(tri_rd), 256'(cyc == 1));
      chk("bp out_valid", 256'(out_valid), 256'(cyc >= 7 && cyc <= 12));
      if (cyc >= 7 && cyc <= 12) chk("bp out_tri", 256'(out_tri), 256'(exp_out(0)));
      chk("bp done", 256'(done), 256'(cyc == 13));
      @(negedge clk);
    end
    chk("bp drawn", 256'(tri_drawn), 256'(1));

    // Clipping on the second triangle
    start = 1'b1; num_tris = 11'd3; out_ready = 1'b1; clip_key = 16'h0001; hs_cnt = 0;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      er = (cyc == 1 || cyc == 8 || cyc == 14);
      chk("clip tri_rd", 256'(tri_rd), 256'(er));
      if (er) chk("clip tri_addr", 256'(tri_addr), 256'(cyc == 1 ? 0 : (cyc == 8 ? 1 : 2)));
      chk("clip out_valid", 256'(out_valid), 256'(cyc == 7 || cyc == 20));
      if (cyc == 7)  chk("clip out_tri0", 256'(out_tri), 256'(exp_out(0)));
      if (cyc == 20) chk("clip out_tri2", 256'(out_tri), 256'(exp_out(2)));
      chk("clip done", 256'(done), 256'(cyc == 21));
      if (out_valid && out_ready) hs_cnt++;
      @(negedge clk);
    end
    chk("clip handshakes", 256'(hs_cnt), 256'(2));
    chk("clip drawn", 256'(tri_drawn), 256'(2));
    chk("clip clipped", 256'(tri_clipped), 256'(1));

    // Empty pass
    clip_key = 16'hFFFF;
    chk("zero busy c0", 256'(busy), 256'(0));
    start = 1'b1; num_tris = 11'd0;
    @(negedge clk); start = 1'b0;
    chk("zero done c1", 256'(done), 256'(1));
    chk("zero busy c1", 256'(busy), 256'(1));
    chk("zero tri_rd c1", 256'(tri_rd), 256'(0));
    chk("zero counts", 256'({tri_drawn, tri_clipped}), 256'(0));
    @(negedge clk);
    chk("zero done c2", 256'(done), 256'(0));
    chk("zero busy c2", 256'(busy), 256'(0));
    chk("zero tri_rd c2", 256'(tri_rd), 256'(0));
    @(negedge clk);

    // Reset during EMIT of the second triangle
    start = 1'b1; num_tris = 11'd3; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    chk("mid out_valid", 256'(out_valid), 256'(1));
    chk("mid drawn", 256'(tri_drawn), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 256'(out_valid), 256'(0));
    chk("mid rst busy", 256'(busy), 256'(0));
    chk("mid rst counts", 256'({tri_drawn, tri_clipped}), 256'(0));
    chk("mid rst out_tri", 256'(out_tri), 256'(0));
    @(negedge clk);
    chk("mid rst done", 256'(done), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst done", 256'(done), 256'(0));
    run_nominal3("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_project_sched.md
# tri_project_sched

Sequencer that streams triangles from the triangle buffer through the shared combinational projection unit and hands surviving screen-space triangles to the rasterizer. It fetches one triangle per pass and holds the unit's inputs stable for a fixed multicycle settle window. It then samples the projected result, drops clipped triangles and emits the rest over a valid/ready handshake. It sits between the triangle buffer (1-cycle synchronous read) and the rasterizer input.

## Interface
- WIIA, 8, integer bits of vertex/MVP fixed-point words
- WIFA, 8, fraction bits of vertex/MVP words (word W = WIIA+WIFA = 16)
- WOI, 12, integer bits of projected screen coordinates
- SETTLE, 4, cycles the projection unit inputs are held before sampling (≥1)
- AW, 10, triangle buffer address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- num_tris  in  AW+1  triangles in this pass; latched at start
- mvp_in  in  16×W  MVP matrix; latched at start
- tri_rd  out  1  buffer read strobe
- tri_addr  out  AW  buffer read address
- tri_data  in  3×4×W  vertices a,b,c (x,y,z,w); valid the cycle after tri_rd
- pu_vertex_a/b/c  out  4×W each  projection unit vertex inputs (registered)
- pu_mvp  out  16×W  projection unit matrix input (registered)
- pu_V1/V2/V3  in  2×WOI each  projected screen x,y
- pu_clip  in  1  projection unit out-of-screen flag
- pu_proj_vertex  in  3×36  packed {x[9:0],y[9:0],z[15:0]} per vertex
- out_valid  out  1  triangle available to rasterizer
- out_ready  in  1  rasterizer accepts
- out_tri  out  3×36  registered copy of pu_proj_vertex
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass
- tri_drawn  out  AW+1  triangles emitted this pass
- tri_clipped  out  AW+1  triangles dropped this pass

## Operation
- States: IDLE, FETCH, WAIT_DATA, SETTLE, EMIT, DONE.
- IDLE: on start, latch num_tris and mvp_in into pu_mvp, clear idx, tri_drawn and tri_clipped. Go to DONE if num_tris==0, else go to FETCH. start is ignored outside IDLE.
- FETCH: tri_rd=1, tri_addr=idx. Next state is WAIT_DATA.
- WAIT_DATA: capture tri_data into pu_vertex_a/b/c at the cycle end, load settle counter with SETTLE-1. Next state is SETTLE.
- SETTLE: decrement the counter. At counter==0, sample pu_proj_vertex into out_tri and evaluate pu_clip.
  - If clip: tri_clipped+1. Next state is DONE if idx==num_tris-1, else FETCH with idx+1.
  - Else: go to EMIT.
- EMIT: out_valid=1; out_tri is held stable until out_valid&&out_ready. On the handshake, tri_drawn+1. Next state is DONE if idx==num_tris-1, else FETCH with idx+1.
- DONE: done=1 for one cycle, then go to IDLE. Counters hold their final values until the next start.
- pu_vertex_* and pu_mvp change only in WAIT_DATA and at start respectively. They are never modified during SETTLE or EMIT.
- Invariant at DONE: tri_drawn + tri_clipped == num_tris.

## Timing
- Reset (async, rst_n=0): state=IDLE. tri_rd, out_valid, busy, done = 0. tri_addr, pu_*, out_tri, tri_drawn, tri_clipped = 0.
- Counting from the start cycle as cycle 0: FETCH is cycle 1, WAIT_DATA is cycle 2, SETTLE is cycles 3..2+SETTLE. With SETTLE=4, EMIT begins at cycle 7.
- Each triangle costs 2+SETTLE cycles when clipped and 3+SETTLE cycles when emitted with out_ready=1. Each stalled cycle adds one.
- out_valid is never deasserted before the handshake; out_tri is stable while out_valid=1.
- num_tris==0: done is high in cycle 1 and no tri_rd is issued.
- Maximum num_tris is 2^AW; idx never wraps within a pass.
- rst_n asserted mid-pass: immediate return to the reset values. No done pulse is issued and no partial counts survive.

## Test plan
- Reset: hold rst_n=0 with start=1 and out_ready=1 → all outputs 0, state IDLE, no tri_rd.
- 3 triangles, none clipped, out_ready=1, SETTLE=4, start at cycle 0 → tri_rd at cycles 1/8/15 with addr 0/1/2; out_valid at cycles 7/14/21; done at cycle 22; tri_drawn=3, tri_clipped=0.
- Backpressure: 1 triangle, out_ready=0 for cycles 7–11, then 1 → out_valid high in cycles 7–12 with out_tri unchanged; handshake at cycle 12; done at cycle 13.
- Clipping: 3 triangles with pu_clip=1 on the second → only 2 handshakes occur; tri_drawn=2, tri_clipped=1; the second pass takes 6 cycles; done at cycle 21.
- num_tris=0 → done at cycle 1, busy high only in cycle 1, counters 0, no tri_rd.
- Reset during EMIT of the second triangle of 3 → out_valid falls asynchronously, counters clear, no done pulse; a subsequent start runs a full pass normally.
